// File: rtl/grade_collector.sv
// Serial-to-parallel grade collector with framing/range flags.
// Holds one assembled applicant record until downstream takes it.
module grade_collector #(
  parameter int MAX_GRADE = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_grade,
  input  logic       in_first,
  output logic [7:0] sect1_grade,
  output logic [7:0] sect2_grade,
  output logic [7:0] sect3_grade,
  output logic [7:0] sect4_grade,
  output logic [9:0] total,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] applicant_cnt,
  output logic       seq_err,
  output logic       range_err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  localparam logic [7:0] MaxG = 8'(MAX_GRADE);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [7:0] s1_q, s2_q, s3_q, s4_q;
  logic [9:0] total_q;
  logic [7:0] cnt_q;
  logic       ov_q;
  logic       seq_q;
  logic       rng_q;

  logic       accept;
  logic       over;
  logic [7:0] g_sat;
  logic [9:0] sum4;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid & in_ready;
  assign over     = (in_grade > MaxG);
  assign g_sat    = over ? MaxG : in_grade;
  // Slot 4 arrives this cycle, so sum the saturated beat directly.
  assign sum4     = {2'b00, s1_q} + {2'b00, s2_q}
                  + {2'b00, s3_q} + {2'b00, g_sat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      s1_q    <= 8'd0;
      s2_q    <= 8'd0;
      s3_q    <= 8'd0;
      s4_q    <= 8'd0;
      total_q <= 10'd0;
      cnt_q   <= 8'd0;
      ov_q    <= 1'b0;
      seq_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      seq_q <= 1'b0;
      rng_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_first) begin
              s1_q    <= g_sat;
              idx_q   <= 2'd1;
              rng_q   <= over;
              state_q <= COLLECT;
            end else begin
              seq_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            rng_q <= over;
            if (in_first) begin
              s1_q  <= g_sat;
              idx_q <= 2'd1;
              seq_q <= 1'b1;
            end else begin
              unique case (1'b1)
                (idx_q == 2'd1): begin
                  s2_q  <= g_sat;
                  idx_q <= 2'd2;
                end
                (idx_q == 2'd2): begin
                  s3_q  <= g_sat;
                  idx_q <= 2'd3;
                end
                (idx_q == 2'd3): begin
                  s4_q    <= g_sat;
                  total_q <= sum4;
                  idx_q   <= 2'd0;
                  ov_q    <= 1'b1;
                  state_q <= HOLD;
                end
                default: begin
                  s1_q  <= s1_q;
                  idx_q <= 2'd1;
                end
              endcase
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            cnt_q   <= cnt_q + 8'd1;
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ov_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sect1_grade   = s1_q;
  assign sect2_grade   = s2_q;
  assign sect3_grade   = s3_q;
  assign sect4_grade   = s4_q;
  assign total         = total_q;
  assign out_valid     = ov_q;
  assign applicant_cnt = cnt_q;
  assign seq_err       = seq_q;
  assign range_err     = rng_q;

endmodule

// File: tb/tb_grade_collector.sv
// Directed bench for grade_collector.
// Each task drives one scenario and checks its own expectations.
module tb_grade_collector;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_grade;
  logic       in_first;
  logic [7:0] sect1_grade, sect2_grade, sect3_grade, sect4_grade;
  logic [9:0] total;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] applicant_cnt;
  logic       seq_err;
  logic       range_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_se  = 0;
  int n_re  = 0;
  logic last_se, last_re;

  grade_collector #(.MAX_GRADE(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_grade     (in_grade),
    .in_first     (in_first),
    .sect1_grade  (sect1_grade),
    .sect2_grade  (sect2_grade),
    .sect3_grade  (sect3_grade),
    .sect4_grade  (sect4_grade),
    .total        (total),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .applicant_cnt(applicant_cnt),
    .seq_err      (seq_err),
    .range_err    (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a beat for one edge; sample error pulses 1 ns later.
  task automatic beat(input logic f, input logic [7:0] g);
    in_valid = 1'b1;
    in_first = f;
    in_grade = g;
    @(posedge clk);
    #1;
    last_se = seq_err;
    last_re = range_err;
    if (seq_err === 1'b1) n_se++;
    if (range_err === 1'b1) n_re++;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_grade = 8'd0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({in_ready, out_valid, seq_err, range_err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 1000",
               {in_ready, out_valid, seq_err, range_err});
    end
    n_cmp++;
    if ({sect1_grade, sect2_grade, sect3_grade, sect4_grade} !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_sects got %h want 0",
               {sect1_grade, sect2_grade, sect3_grade, sect4_grade});
    end
    n_cmp++;
    if (total !== 10'd0 || applicant_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_total_cnt got %0d/%0d want 0/0", total, applicant_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    n_se = 0; n_re = 0;
    beat(1'b1, 8'd30);
    beat(1'b0, 8'd25);
    beat(1'b0, 8'd20);
    beat(1'b0, 8'd35);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_valid got ov=%b ir=%b want 1/0", out_valid, in_ready);
    end
    n_cmp++;
    if ({sect1_grade, sect2_grade, sect3_grade, sect4_grade} !==
        {8'd30, 8'd25, 8'd20, 8'd35}) begin
      n_bad++;
      $display("FAIL basic_sects got %0d/%0d/%0d/%0d want 30/25/20/35",
               sect1_grade, sect2_grade, sect3_grade, sect4_grade);
    end
    n_cmp++;
    if (total !== 10'd110) begin
      n_bad++;
      $display("FAIL basic_total got %0d want 110", total);
    end
    idle_cycle();
    n_cmp++;
    if (applicant_cnt !== 8'd1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_cnt got %0d ov=%b want 1 ov=0", applicant_cnt, out_valid);
    end
    n_cmp++;
    if (n_se != 0 || n_re != 0) begin
      n_bad++;
      $display("FAIL basic_noerr got se=%0d re=%0d want 0/0", n_se, n_re);
    end
  endtask

  task automatic test_stall();
    int bad;
    out_ready = 1'b0;
    beat(1'b1, 8'd100);
    beat(1'b0, 8'd100);
    beat(1'b0, 8'd100);
    beat(1'b0, 8'd100);
    n_cmp++;
    if (total !== 10'd400 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_total got %0d ov=%b want 400 ov=1", total, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, 8'd77);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || total !== 10'd400 ||
          sect1_grade !== 8'd100 || sect4_grade !== 8'd100 || last_se !== 1'b0)
        bad++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL stall_hold got %0d unstable cycles want 0", bad);
    end
    out_ready = 1'b1;
    idle_cycle();
    n_cmp++;
    if (applicant_cnt !== 8'd2 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        sect1_grade !== 8'd100) begin
      n_bad++;
      $display("FAIL stall_release got cnt=%0d ov=%b ir=%b s1=%0d want 2/0/1/100",
               applicant_cnt, out_valid, in_ready, sect1_grade);
    end
  endtask

  task automatic test_saturate();
    logic first_re;
    n_re = 0;
    beat(1'b1, 8'd250);
    first_re = last_re;
    beat(1'b0, 8'd10);
    beat(1'b0, 8'd10);
    beat(1'b0, 8'd10);
    in_valid = 1'b0;
    n_cmp++;
    if (sect1_grade !== 8'd100 || total !== 10'd130) begin
      n_bad++;
      $display("FAIL sat_value got s1=%0d tot=%0d want 100/130", sect1_grade, total);
    end
    n_cmp++;
    if (first_re !== 1'b1 || n_re != 1) begin
      n_bad++;
      $display("FAIL sat_rangeerr got first=%b count=%0d want 1/1", first_re, n_re);
    end
    idle_cycle();
  endtask

  task automatic test_seq();
    beat(1'b0, 8'd50);
    in_valid = 1'b0;
    n_cmp++;
    if (last_se !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL seq_idle got se=%b ir=%b ov=%b want 1/1/0",
               last_se, in_ready, out_valid);
    end
    beat(1'b0, 8'd200);
    in_valid = 1'b0;
    n_cmp++;
    if (last_se !== 1'b1 || last_re !== 1'b0) begin
      n_bad++;
      $display("FAIL seq_idle_over got se=%b re=%b want 1/0", last_se, last_re);
    end
    beat(1'b1, 8'd40);
    beat(1'b0, 8'd41);
    beat(1'b1, 8'd60);
    n_cmp++;
    if (last_se !== 1'b1 || sect1_grade !== 8'd60) begin
      n_bad++;
      $display("FAIL seq_restart got se=%b s1=%0d want 1/60", last_se, sect1_grade);
    end
    beat(1'b0, 8'd0);
    beat(1'b0, 8'd0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL seq_early got ov=%b want 0", out_valid);
    end
    beat(1'b0, 8'd0);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || sect1_grade !== 8'd60 || total !== 10'd60) begin
      n_bad++;
      $display("FAIL seq_record got ov=%b s1=%0d tot=%0d want 1/60/60",
               out_valid, sect1_grade, total);
    end
    idle_cycle();
    n_cmp++;
    if (applicant_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL seq_cnt got %0d want 4", applicant_cnt);
    end
  endtask

  task automatic test_reset_mid();
    beat(1'b1, 8'd11);
    beat(1'b0, 8'd12);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (applicant_cnt !== 8'd0 || sect1_grade !== 8'd0 || sect2_grade !== 8'd0 ||
        total !== 10'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_async got cnt=%0d s1=%0d s2=%0d tot=%0d ir=%b ov=%b",
               applicant_cnt, sect1_grade, sect2_grade, total, in_ready, out_valid);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat(1'b1, 8'd1);
    beat(1'b0, 8'd2);
    beat(1'b0, 8'd3);
    beat(1'b0, 8'd4);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || total !== 10'd10 || sect4_grade !== 8'd4) begin
      n_bad++;
      $display("FAIL rstmid_after got ov=%b tot=%0d s4=%0d want 1/10/4",
               out_valid, total, sect4_grade);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] c255;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    c255 = 8'hxx;
    for (int a = 1; a <= 256; a++) begin
      beat(1'b1, 8'(a % 101));
      beat(1'b0, 8'd1);
      beat(1'b0, 8'd2);
      beat(1'b0, 8'd3);
      in_valid = 1'b0;
      if (a == 256) begin
        n_cmp++;
        if (total !== 10'(a % 101 + 6)) begin
          n_bad++;
          $display("FAIL b2b_total got %0d want %0d", total, a % 101 + 6);
        end
      end
      idle_cycle();
      if (a == 255) c255 = applicant_cnt;
    end
    n_cmp++;
    if (c255 !== 8'd255) begin
      n_bad++;
      $display("FAIL b2b_cnt255 got %0d want 255", c255);
    end
    n_cmp++;
    if (applicant_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL b2b_wrap got %0d want 0", applicant_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_saturate();
    test_seq();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grade_collector.md
# grade_collector

Input-side stage for the applicant classifier. Accepts one applicant's four section grades as a serial byte stream with a valid/ready handshake. Assembles them into four parallel 8-bit grades plus a registered 10-bit total, and holds the record under an out_valid/out_ready handshake until the classifier side takes it. Also flags framing and range errors and counts completed applicants.

## Interface
- MAX_GRADE, 100: highest legal per-section grade; larger inputs saturate to this value.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_grade/in_first valid this cycle.
- in_ready  output  1  stage can accept a grade beat.
- in_grade  input  8  unsigned section grade.
- in_first  input  1  beat is section 1 of a new applicant.
- sect1_grade .. sect4_grade  output  8 each  assembled grades, stable while out_valid.
- total  output  10  sect1+sect2+sect3+sect4 after saturation.
- out_valid  output  1  assembled record available.
- out_ready  input  1  downstream accepts record.
- applicant_cnt  output  8  records handed off since reset; wraps.
- seq_err  output  1  one-cycle pulse on framing error.
- range_err  output  1  one-cycle pulse when an accepted grade exceeds MAX_GRADE.

## Operation
- Accept = in_valid & in_ready. Handoff = out_valid & out_ready.
- States:
  - IDLE: waiting for section 1.
  - COLLECT: holds sections 1..3; a 2-bit index gives the next slot.
  - HOLD: record complete.
- in_ready = 1 in IDLE and COLLECT, 0 in HOLD. out_valid = 1 only in HOLD.
- IDLE, accepted beat:
  - in_first=1: store into sect1, index=1, go to COLLECT.
  - in_first=0: discard the beat, pulse seq_err, stay in IDLE.
- COLLECT, accepted beat:
  - in_first=1: restart. Store into sect1, index=1, pulse seq_err. The earlier partial grades are not required to be cleared.
  - in_first=0: store into slot[index] and increment index.
  - Storing slot 4 also registers total and moves to HOLD.
- HOLD: on handoff, applicant_cnt increments (255 wraps to 0) and the state goes to IDLE. Without handoff, all record outputs hold.
- Saturation: a grade above MAX_GRADE is stored as MAX_GRADE and range_err pulses. A beat that is both framing-bad in IDLE and over range is discarded: seq_err pulses, range_err stays 0.
- Arithmetic: total is a zero-extended unsigned 10-bit sum. Max 4*255 = 1020, so there is no overflow.
- Reset (asynchronous, any state): state IDLE, index 0, all sect grades 0, total 0, out_valid 0, applicant_cnt 0, seq_err 0, range_err 0. in_ready is 1 once in IDLE, including during reset. A partially collected applicant is lost.

## Timing
- All state and outputs are registered on the rising clk, except in_ready, which is decoded from the state.
- Latency: out_valid rises the cycle after the 4th beat is accepted. total is valid the same cycle.
- Minimum period per applicant is 5 cycles: 4 accept cycles plus 1 HOLD cycle with out_ready=1.
- in_valid may drop between beats. Idle gaps do not disturb collection.
- seq_err and range_err pulse the cycle after the offending beat is accepted.
- applicant_cnt updates the cycle after handoff.
- The sect grades and total are not modified between handoff and the next 4th beat.

## Test plan
- Reset then beats (first=1,30),(0,25),(0,20),(0,35) back-to-back, out_ready=1 -> out_valid high 1 cycle after the 4th beat with grades 30/25/20/35 and total=110; applicant_cnt=1 next cycle; no error pulses.
- Beats 100,100,100,100 with out_ready=0 for 6 cycles, then 1 -> in_ready=0 and outputs stable through the stall; total=400; a beat presented during the stall is not accepted.
- Beats 250,10,10,10 with MAX_GRADE=100 -> sect1=100, total=130, one range_err pulse after the first beat.
- Beat (first=0,50) in IDLE -> seq_err pulse and state stays IDLE. Then 2 beats, then (first=1,60),0,0,0 -> seq_err pulse, sect1=60, total=60.
- rst_n low for 1 cycle mid-collection after 2 beats -> all outputs return to reset values immediately; a following 4-beat applicant completes normally.
- 256 back-to-back applicants -> applicant_cnt reads 255 after the 255th and 0 after the 256th.
